// File: rtl/spi_mstr_gen_pkg.sv
// spi_pkg: shared types and constants for the parametrised SPI master.
//   spi_state_t  frame sequencer states
//   SPI_MODE0-3  {CPOL,CPHA} encodings for the mode input
package spi_pkg;
    typedef enum logic [2:0] {IDLE, FRONT, BITS, BACK, HOLD} spi_state_t;
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;
endpackage

// File: rtl/spi_mstr_gen_sclk_gen.sv
// spi_sclk_gen: SCLK divider with half-period strobes and a registered SCLK.
//   clk, rst    system clock, async active-high reset
//   clr         restart the divider (frame start)
//   tog         toggle SCLK this clk
//   park        force SCLK to pol this clk (takes priority over tog)
//   pol         idle level used while parked
//   half_stb    last clk of each half period
//   lead_stb    half_stb that ends an even half period (leading edge slot)
//   trail_stb   half_stb that ends an odd half period (trailing edge slot)
//   sclk        registered serial clock
module spi_sclk_gen #(
    parameter int DIV_W = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tog,
    input  logic park,
    input  logic pol,
    output logic half_stb,
    output logic lead_stb,
    output logic trail_stb,
    output logic sclk
);
    logic [DIV_W-1:0] cnt;
    // cnt holds (clks since clr - 1), so every H-th clk after clr strobes
    assign half_stb  = &cnt[DIV_W-2:0];
    assign lead_stb  = half_stb & ~cnt[DIV_W-1];
    assign trail_stb = half_stb & cnt[DIV_W-1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else begin
            cnt  <= clr ? '0 : cnt + 1'b1;
            sclk <= park ? pol : (tog ? ~sclk : sclk);
        end
    end
endmodule

// File: rtl/spi_mstr_gen.sv
// spi_mstr_gen: SPI master with generic width, SCLK divider, modes 0-3,
// NUM_SS selects and a hold option keeping SS_n low across frames.
//   clk, rst   system clock, async active-high reset
//   wrt        start pulse, accepted in IDLE or HOLD
//   cmd        word to send (MSB first), mode {CPOL,CPHA}, ss_sel slave index
//   hold       keep SS_n low after frame end
//   MISO       serial input; SS_n, SCLK, MOSI serial outputs
//   busy       frame in progress; done sticky frame-complete flag
//   rd_data    received word
module spi_mstr_gen
    import spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIV_W = 5,
    parameter int NUM_SS = 1,
    localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              hold,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n,
    output logic              SCLK,
    output logic              MOSI,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);
    localparam int CW = $clog2(DATA_W) + 1;
    spi_state_t state;
    logic [DATA_W-1:0] tx_q, rx_q;
    logic [1:0] mode_q;
    logic [CW-1:0] bcnt;
    logic half_stb, lead_stb, trail_stb;
    logic acc, lead, trail, last, smp, sft, pol;
    assign acc   = wrt & (state == IDLE || state == HOLD);
    // the first leading edge falls on the last clk of FRONT
    assign lead  = lead_stb & (state == FRONT || state == BITS);
    assign trail = trail_stb & (state == BITS);
    assign last  = bcnt == CW'(DATA_W - 1);
    assign smp   = mode_q[0] ? trail : lead;
    assign sft   = mode_q[0] ? (lead & (bcnt != '0)) : (trail & ~last);
    // a new frame must start at the new CPOL even when coming out of HOLD
    assign pol   = (state == IDLE || acc) ? mode[1] : mode_q[1];
    assign MOSI    = tx_q[DATA_W-1];
    assign rd_data = rx_q;
    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk (
        .clk(clk), .rst(rst), .clr(acc),
        .tog(half_stb & (state == FRONT || state == BITS)),
        .park(state == IDLE || state == HOLD || acc), .pol(pol),
        .half_stb(half_stb), .lead_stb(lead_stb), .trail_stb(trail_stb), .sclk(SCLK)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            SS_n   <= '1;
            busy   <= 1'b0;
            done   <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
            mode_q <= '0;
            bcnt   <= '0;
        end else begin
            if (acc) begin
                state  <= FRONT;
                tx_q   <= cmd;
                mode_q <= mode;
                bcnt   <= '0;
                busy   <= 1'b1;
                done   <= 1'b0;
                // out-of-range ss_sel shifts the one-hot away: no select asserted
                if (state == IDLE) SS_n <= ~(NUM_SS'(1) << ss_sel);
            end else begin
                case (state)
                    IDLE:  SS_n <= '1;
                    FRONT: if (lead) state <= BITS;
                    BITS: if (trail) begin
                        bcnt <= bcnt + CW'(1);
                        if (last) state <= BACK;
                    end
                    BACK: if (half_stb) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= hold ? HOLD : IDLE;
                        if (!hold) SS_n <= '1;
                    end
                    HOLD: if (!hold) begin
                        state <= IDLE;
                        SS_n  <= '1;
                    end
                    default: state <= IDLE;
                endcase
            end
            if (smp) rx_q <= {rx_q[DATA_W-2:0], MISO};
            if (sft) tx_q <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_spi_mstr_gen.sv
// tb_spi_mstr_gen: directed bench for spi_mstr_gen with a cycle-stepped slave model.
module tb_spi_mstr_gen;
    import spi_pkg::*;
    typedef struct {
        logic [1:0] m;
        logic [7:0] cmd;
        logic [7:0] word;
        logic [7:0] exp_rd;
        logic [7:0] exp_tx;
    } vec_t;
    logic clk = 0, rst = 1;
    logic wrt_a = 0, wrt_b = 0, hold = 0, ss_sel = 0, loop = 0, sel = 0, mon = 0;
    logic [1:0] mode = 0;
    logic [15:0] cmd = 0, sh = 0, s_rx = 0;
    logic s_prev = 0, s_cpol = 0, s_cpha = 0;
    logic miso_a, miso_b, sclk_a, sclk_b, mosi_a, mosi_b, busy_a, busy_b, done_a, done_b;
    logic [1:0] ss_a;
    logic [0:0] ss_b;
    logic [15:0] rd_a;
    logic [7:0] rd_b;
    int s_edges = 0, n_rise = 0, ss_lo = 0, hi1 = 0, lo0 = 0, cyc = 0, t0 = 0, ss_idx = 0;
    int nchk = 0, nerr = 0, lat;
    vec_t tv[7];

    assign miso_a = loop ? mosi_a : sh[15];
    assign miso_b = sh[15];

    spi_mstr_gen #(.DATA_W(16), .DIV_W(5), .NUM_SS(2)) dut_a (
        .clk(clk), .rst(rst), .wrt(wrt_a), .cmd(cmd), .mode(mode), .ss_sel(ss_sel),
        .hold(hold), .MISO(miso_a), .SS_n(ss_a), .SCLK(sclk_a), .MOSI(mosi_a),
        .busy(busy_a), .done(done_a), .rd_data(rd_a));
    spi_mstr_gen #(.DATA_W(8), .DIV_W(3), .NUM_SS(1)) dut_b (
        .clk(clk), .rst(rst), .wrt(wrt_b), .cmd(cmd[7:0]), .mode(mode), .ss_sel(ss_sel),
        .hold(hold), .MISO(miso_b), .SS_n(ss_b), .SCLK(sclk_b), .MOSI(mosi_b),
        .busy(busy_b), .done(done_b), .rd_data(rd_b));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // one clk step; slave model reacts to SCLK edges seen at the falling clk edge
    task automatic tick();
        logic sc, mo;
        @(negedge clk);
        cyc++;
        sc = sel ? sclk_b : sclk_a;
        mo = sel ? mosi_b : mosi_a;
        if (sc != s_prev) begin
            if (sc) n_rise++;
            if ((sc != s_cpol) != s_cpha) s_rx = {s_rx[14:0], mo};
            else if (!(s_cpha && s_edges == 0)) sh = sh << 1;
            s_edges++;
        end
        s_prev = sc;
        if (sel ? !ss_b[0] : !ss_a[ss_idx]) ss_lo++;
        if (mon) begin
            if (ss_a[1]) hi1++;
            if (!ss_a[0]) lo0++;
        end
    endtask

    task automatic start(input logic [1:0] m, input logic [15:0] c, input logic [15:0] w,
                         input logic s, input logic h);
        if (mode != m) begin
            mode = m;
            tick();
        end
        cmd = c; ss_sel = s; hold = h;
        if (sel) wrt_b = 1; else wrt_a = 1;
        sh = sel ? {w[7:0], 8'h00} : w;
        s_rx = 0; s_edges = 0; n_rise = 0; ss_lo = 0;
        s_cpol = m[1]; s_cpha = m[0];
        s_prev = sel ? sclk_b : sclk_a;
        tick();
        t0 = cyc;
        wrt_a = 0; wrt_b = 0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int i = 0; i < 4000; i++) begin
            if (sel ? done_b : done_a) begin
                l = cyc - t0;
                break;
            end
            tick();
        end
    endtask

    initial begin
        tv[0] = '{SPI_MODE1, 8'h81, 8'h7E, 8'h7E, 8'h81};
        tv[1] = '{SPI_MODE0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
        tv[2] = '{SPI_MODE2, 8'hF0, 8'h0F, 8'h0F, 8'hF0};
        tv[3] = '{SPI_MODE3, 8'h5A, 8'hC3, 8'hC3, 8'h5A};
        tv[4] = '{SPI_MODE0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        tv[5] = '{SPI_MODE1, 8'hFF, 8'h00, 8'h00, 8'hFF};
        tv[6] = '{SPI_MODE3, 8'h01, 8'h80, 8'h80, 8'h01};
        repeat (3) tick();
        chk("rst_ss_n", 32'(ss_a), 32'h3);
        chk("rst_sclk", 32'(sclk_a), 0);
        chk("rst_mosi", 32'(mosi_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_rd", 32'(rd_a), 0);
        rst = 0;
        tick();

        // mode0 loopback
        loop = 1;
        start(SPI_MODE0, 16'hA5C3, 16'h0000, 0, 0);
        chk("t1_busy", 32'(busy_a), 1);
        chk("t1_done0", 32'(done_a), 0);
        wait_done(lat);
        chk("t1_lat", 32'(lat), 528);
        chk("t1_rd", 32'(rd_a), 32'hA5C3);
        chk("t1_ss_low", 32'(ss_lo), 528);
        chk("t1_rise", 32'(n_rise), 16);
        repeat (3) tick();
        chk("t1_done_sticky", 32'(done_a), 1);
        chk("t1_busy_end", 32'(busy_a), 0);
        loop = 0;

        // mode3
        start(SPI_MODE3, 16'hC0DE, 16'h1234, 0, 0);
        chk("t2_done_clr", 32'(done_a), 0);
        wait_done(lat);
        chk("t2_rd", 32'(rd_a), 32'h1234);
        chk("t2_tx", 32'(s_rx), 32'hC0DE);
        chk("t2_rise", 32'(n_rise), 16);
        tick();
        chk("t2_sclk_idle", 32'(sclk_a), 1);

        // wrt while busy is ignored
        start(SPI_MODE0, 16'h4C71, 16'h8E19, 0, 0);
        while (cyc < t0 + 99) tick();
        cmd = 16'hFFFF; wrt_a = 1;
        tick();
        wrt_a = 0;
        chk("t4_busy", 32'(busy_a), 1);
        chk("t4_done", 32'(done_a), 0);
        wait_done(lat);
        chk("t4_lat", 32'(lat), 528);
        chk("t4_rd", 32'(rd_a), 32'h8E19);
        chk("t4_tx", 32'(s_rx), 32'h4C71);
        chk("t4_ss_low", 32'(ss_lo), 528);

        // hold across two frames on slave 1; second wrt coincides with hold=0
        ss_idx = 1; hi1 = 0; lo0 = 0;
        start(SPI_MODE0, 16'hDEAD, 16'h1111, 1, 1);
        mon = 1;
        wait_done(lat);
        chk("t3_lat1", 32'(lat), 528);
        repeat (5) tick();
        chk("t3_hold_ss", 32'(ss_a), 32'h1);
        start(SPI_MODE0, 16'hBEEF, 16'h2222, 0, 0);
        hold = 1;
        chk("t3_busy2", 32'(busy_a), 1);
        wait_done(lat);
        chk("t3_lat2", 32'(lat), 528);
        chk("t3_rd2", 32'(rd_a), 32'h2222);
        chk("t3_tx2", 32'(s_rx), 32'hBEEF);
        repeat (3) tick();
        hold = 0; mon = 0;
        tick();
        chk("t3_ss1_high", 32'(ss_a), 32'h3);
        chk("t3_ss1_gap", 32'(hi1), 0);
        chk("t3_ss0_low", 32'(lo0), 0);
        ss_idx = 0;

        // async reset in the middle of bit 7
        start(SPI_MODE0, 16'h1357, 16'h2468, 0, 0);
        while (cyc < t0 + 240) tick();
        rst = 1;
        #1;
        chk("t5_ss_n", 32'(ss_a), 32'h3);
        chk("t5_sclk", 32'(sclk_a), 0);
        chk("t5_busy", 32'(busy_a), 0);
        chk("t5_done", 32'(done_a), 0);
        chk("t5_rd", 32'(rd_a), 0);
        tick();
        rst = 0;
        repeat (2) tick();
        start(SPI_MODE1, 16'h6B1D, 16'h9E2F, 0, 0);
        wait_done(lat);
        chk("t5_lat", 32'(lat), 528);
        chk("t5_rd2", 32'(rd_a), 32'h9E2F);
        chk("t5_tx2", 32'(s_rx), 32'h6B1D);
        chk("t5_rise", 32'(n_rise), 16);

        // 8-bit, DIV_W=3 instance: vector table across all modes
        sel = 1;
        for (int i = 0; i < 7; i++) begin
            start(tv[i].m, {8'h00, tv[i].cmd}, {8'h00, tv[i].word}, 0, 0);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 68);
            chk($sformatf("v%0d_rd", i), 32'(rd_b), 32'(tv[i].exp_rd));
            chk($sformatf("v%0d_tx", i), 32'(s_rx[7:0]), 32'(tv[i].exp_tx));
            chk($sformatf("v%0d_rise", i), 32'(n_rise), 8);
            chk($sformatf("v%0d_ss_low", i), 32'(ss_lo), 68);
            tick();
        end

        // ss_sel beyond NUM_SS: no select, frame still runs
        start(SPI_MODE0, 16'h0096, 16'h0069, 1, 0);
        wait_done(lat);
        chk("oor_ss_low", 32'(ss_lo), 0);
        chk("oor_lat", 32'(lat), 68);
        chk("oor_rd", 32'(rd_b), 32'h69);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
